// File: rtl/pe_pkg.sv
// Shared types and constant helpers for the pe_v3 processing element and its requantiser.
package pe_pkg;

  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    wide_t value;
    logic  sat;
  } sat_result_t;

  function automatic int prod_w(int width_a, int width_b);
    return width_a + width_b;
  endfunction

  function automatic int acc_w(int width_a, int width_b, int guard);
    return width_a + width_b + guard;
  endfunction

  function automatic int shift_s(int frac_a, int frac_b, int frac_out);
    return frac_a + frac_b - frac_out;
  endfunction

  function automatic wide_t smax(int width);
    return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t smin(int width);
    return -(wide_t'(1) <<< (width - 1));
  endfunction

  // Half-LSB bias for round half-up; a zero shift has nothing to round.
  function automatic wide_t round_bias(int shift);
    return (shift > 0) ? (wide_t'(1) <<< (shift - 1)) : wide_t'(0);
  endfunction

  function automatic sat_result_t clamp(wide_t x, int width);
    sat_result_t r;
    r.value = x;
    r.sat   = 1'b0;
    if (x > smax(width)) begin
      r.value = smax(width);
      r.sat   = 1'b1;
    end else if (x < smin(width)) begin
      r.value = smin(width);
      r.sat   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_v3_if.sv
// Operand beat, pass-through and result handshake bundle of one pe_v3 instance.
interface pe_v3_if #(
  parameter int WIDTH_A   = 8,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_OUT = 20
);
  logic                        in_valid;
  logic                        in_first;
  logic                        in_last;
  logic signed [WIDTH_A-1:0]   in_west;
  logic signed [WIDTH_B-1:0]   in_north;
  logic signed [WIDTH_A-1:0]   out_east;
  logic signed [WIDTH_B-1:0]   out_south;
  logic                        out_valid;
  logic                        out_first;
  logic                        out_last;
  logic signed [WIDTH_OUT-1:0] result;
  logic                        result_valid;
  logic                        result_ready;
  logic                        result_sat;
  logic                        ovf_err;

  modport master (
    output in_valid, in_first, in_last, in_west, in_north, result_ready,
    input  out_east, out_south, out_valid, out_first, out_last,
    input  result, result_valid, result_sat, ovf_err
  );

  modport slave (
    input  in_valid, in_first, in_last, in_west, in_north, result_ready,
    output out_east, out_south, out_valid, out_first, out_last,
    output result, result_valid, result_sat, ovf_err
  );
endinterface

// File: rtl/pe_requant.sv
// Combinational requantiser: arithmetic shift, optional round half-up (PE_V3_ROUND_EN), saturate.
module pe_requant
  import pe_pkg::*;
#(
  parameter int ACC_W     = 28,
  parameter int WIDTH_OUT = 20,
  parameter int SHIFT     = 4
) (
  input  logic signed [ACC_W-1:0]     acc,
  output logic signed [WIDTH_OUT-1:0] value,
  output logic                        sat
);

  // One extra bit so the rounding bias can never wrap the accumulator.
  localparam int EXT_W = ACC_W + 1;

  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] shifted;
  wide_t                   wide;
  sat_result_t             q;
  logic                    unused_hi;

  always_comb begin
    biased = {acc[ACC_W-1], acc};
`ifdef PE_V3_ROUND_EN
    biased = biased + EXT_W'(round_bias(SHIFT));
`endif
    shifted = biased >>> SHIFT;
    wide    = {{(WIDE_W-EXT_W){shifted[EXT_W-1]}}, shifted};
    q       = clamp(wide, WIDTH_OUT);
  end

  assign value     = q.value[WIDTH_OUT-1:0];
  assign sat       = q.sat;
  assign unused_hi = ^q.value[WIDE_W-1:WIDTH_OUT];

endmodule

// File: rtl/pe_v3.sv
// Output-stationary systolic PE: pipelined MAC with guard bits, requantised result behind valid/ready.
// Optional rounding in the requantiser is enabled by defining PE_V3_ROUND_EN.
module pe_v3
  import pe_pkg::*;
#(
  parameter int WIDTH_A        = 8,
  parameter int FRAC_WIDTH_A   = 4,
  parameter int WIDTH_B        = 16,
  parameter int FRAC_WIDTH_B   = 8,
  parameter int WIDTH_OUT      = 20,
  parameter int FRAC_WIDTH_OUT = 8,
  parameter int ACC_GUARD      = 4
) (
  input logic     clk,
  input logic     rst,
  pe_v3_if.slave  bus
);

  localparam int PROD_W = prod_w(WIDTH_A, WIDTH_B);
  localparam int ACC_W  = acc_w(WIDTH_A, WIDTH_B, ACC_GUARD);
  localparam int SUM_W  = ACC_W + 1;
  localparam int S      = shift_s(FRAC_WIDTH_A, FRAC_WIDTH_B, FRAC_WIDTH_OUT);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(smax(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(smin(ACC_W));

  logic signed [PROD_W-1:0]    prod;
  logic signed [PROD_W-1:0]    p_prod;
  logic                        p_valid;
  logic                        p_first;
  logic                        p_last;
  logic signed [ACC_W-1:0]     acc;
  logic                        acc_sat;
  logic signed [SUM_W-1:0]     sum;
  logic signed [ACC_W-1:0]     acc_next;
  logic                        acc_sat_next;
  logic signed [WIDTH_OUT-1:0] rq_value;
  logic                        rq_sat;
  logic                        load;

  assign prod = PROD_W'(bus.in_west) * PROD_W'(bus.in_north);
  assign load = p_valid && p_last;

  // A first beat restarts from zero and drops the previous saturation history.
  always_comb begin
    sum          = (p_first ? {SUM_W{1'b0}} : SUM_W'(acc)) + SUM_W'(p_prod);
    acc_next     = acc;
    acc_sat_next = acc_sat;
    if (p_valid) begin
      acc_sat_next = p_first ? 1'b0 : acc_sat;
      if (sum[SUM_W-1] != sum[SUM_W-2]) begin
        acc_next     = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
        acc_sat_next = 1'b1;
      end else begin
        acc_next = sum[ACC_W-1:0];
      end
    end
  end

  pe_requant #(
    .ACC_W     (ACC_W),
    .WIDTH_OUT (WIDTH_OUT),
    .SHIFT     (S)
  ) u_requant (
    .acc   (acc_next),
    .value (rq_value),
    .sat   (rq_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_east     <= '0;
      bus.out_south    <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_first    <= 1'b0;
      bus.out_last     <= 1'b0;
      p_valid          <= 1'b0;
      p_first          <= 1'b0;
      p_last           <= 1'b0;
      p_prod           <= '0;
      acc              <= '0;
      acc_sat          <= 1'b0;
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      bus.result_sat   <= 1'b0;
      bus.ovf_err      <= 1'b0;
    end else begin
      bus.out_east  <= bus.in_west;
      bus.out_south <= bus.in_north;
      bus.out_valid <= bus.in_valid;
      bus.out_first <= bus.in_first;
      bus.out_last  <= bus.in_last;
      p_valid       <= bus.in_valid;
      if (bus.in_valid) begin
        p_prod  <= prod;
        p_first <= bus.in_first;
        p_last  <= bus.in_last;
      end
      acc     <= acc_next;
      acc_sat <= acc_sat_next;
      // A load wins over an accept; only an unaccepted pending result counts as lost.
      if (load) begin
        bus.result       <= rq_value;
        bus.result_sat   <= acc_sat_next | rq_sat;
        bus.result_valid <= 1'b1;
        if (bus.result_valid && !bus.result_ready) begin
          bus.ovf_err <= 1'b1;
        end
      end else if (bus.result_valid && bus.result_ready) begin
        bus.result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pe_v3.md
# pe_v3

Parametrised output-stationary processing element for the systolic matrix-multiply array, successor to pe_v2. Operands flow west→east and north→south through registered pass-through, with valid and first/last tags. Products accumulate at full precision with guard bits, and are requantised (round, saturate) only once per dot product. Each finished result is held in an output register behind a valid/ready handshake.

## Interface
- WIDTH_A, 8: signed west operand width
- FRAC_WIDTH_A, 4: fractional bits of A
- WIDTH_B, 16: signed north operand width
- FRAC_WIDTH_B, 8: fractional bits of B
- WIDTH_OUT, 20: signed result width
- FRAC_WIDTH_OUT, 8: fractional bits of result; must satisfy FRAC_WIDTH_A+FRAC_WIDTH_B >= FRAC_WIDTH_OUT
- ACC_GUARD, 4: extra accumulator MSBs; ACC_W = WIDTH_A+WIDTH_B+ACC_GUARD
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_first  in  1  beat starts a new dot product
- in_last  in  1  beat ends the dot product
- in_west  in  WIDTH_A  operand A
- in_north  in  WIDTH_B  operand B
- out_east  out  WIDTH_A  registered in_west
- out_south  out  WIDTH_B  registered in_north
- out_valid, out_first, out_last  out  1 each  registered in_valid, in_first, in_last; these feed both neighbours
- result  out  WIDTH_OUT  requantised dot product
- result_valid  out  1  result held and pending
- result_ready  in  1  consumer accepts result
- result_sat  out  1  pending result was saturated (accumulator or output)
- ovf_err  out  1  sticky flag: a result was overwritten before it was accepted

## Operation
- Pass-through: out_east, out_south and the out tags register their inputs every cycle, whatever in_valid is.
- Stage 1, when in_valid: prod = in_west × in_north, signed, width WIDTH_A+WIDTH_B, frac FRAC_A+FRAC_B. prod, first and last are registered with a valid bit (p_valid).
- Stage 2, when p_valid: acc = p_first ? prod : acc + prod.
  - On signed overflow of ACC_W, acc clamps to max/min and acc_sat is set.
  - p_first clears acc_sat before this beat's update.
  - When p_valid is low, acc holds.
- Requantise, when p_valid and p_last:
  - Arithmetic right shift by S = FRAC_A+FRAC_B−FRAC_OUT, with the rounding mode set in Configuration.
  - Saturate to the signed WIDTH_OUT range.
  - Load result. Set result_valid=1. result_sat = acc_sat OR output clamp.
- When first and last are on the same beat, result equals that single product, requantised.
- Handshake: result_valid stays high and result stays stable until a cycle with result_ready=1, which clears result_valid.
- Load while still pending (result_valid=1 and result_ready=0): new result overwrites the old one, result_valid stays 1, ovf_err is set.
- Load and accept in the same cycle: the new result is loaded, result_valid stays 1, and ovf_err is not set.
- A beat with neither first nor last after an in_last beat continues accumulating from the previous acc; upstream must assert first to start a new dot product.
- rst: all registers clear to 0, including acc, every output and ovf_err. A partial accumulation is discarded and an in-flight stage-1 beat is dropped.

## Timing
- Pass-through latency is 1 cycle: a beat on in_* at edge t appears on out_* after edge t.
- Result latency is 2 cycles: in_last sampled at edge t → result_valid=1 after edge t+1.
- Throughput is 1 beat per cycle; there is no backpressure on the operand path.
- result_ready is sampled only while result_valid=1.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro PE_V3_ROUND_EN.
- Defined: round half-up. Add 2^(S−1) before the shift (skip when S=0), then saturate.
- Undefined: truncate, i.e. plain arithmetic shift toward −∞.

## Structure
- Shared package pe_pkg holds:
  - ACC_W, product-width and S derivation functions
  - signed max/min constant functions
  - a sat_result_t struct {value, sat}
- One sub-module, pe_requant: combinational shift, round, saturate from ACC_W to WIDTH_OUT, also reporting the clamp. It is reused by future array-edge drain logic.

## Test plan
Default parameters; values are Q4.4 × Q8.8 → Q12.8.
- Basic accumulate: beat 1 is 1.5 (0x18) × 2.0 (0x0200) with first; beat 2 is 1.0 × −3.0 with last. Expect result=0x00000, result_valid=1 two cycles after beat 2, result_sat=0.
- Positive saturation: four beats of 7.9375 (0x7F) × 127.99 (0x7FFF), first on beat 1, last on beat 4. Expect result=0x7FFFF, result_sat=1.
- Negative saturation: three beats of −8.0 (0x80) × 127.0 (0x7F00), tagged first…last. Expect result=0x80000, result_sat=1.
- Rounding: one beat of 0.5 (0x08) × 2^-8 (0x0001) with first+last. Expect result=0x00001 with PE_V3_ROUND_EN, 0x00000 without.
- Handshake and overflow:
  - With result_ready=0, complete two single-beat dot products, 2.25×2.5 then 1.0×1.0. Expect result=0x00100, ovf_err=1.
  - Then raise result_ready for 1 cycle. Expect result_valid=0.
  - Repeat with result_ready=1 at the second load. Expect ovf_err stays 0 (after a reset).
- Reset mid-operation: assert rst for 1 cycle between a first beat and its last beat. Expect all outputs 0. Then a fresh first+last beat 1.0×1.0 gives result=0x00100.
